// File: rtl/ula_pkg.sv
// Shared types and decode for the sequential ALU (ula_seq).
package ula_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE, ST_CALC, ST_FIX, ST_DONE
  } state_t;

  function automatic alu_op_t decode(input logic [6:0] opcode, input logic [6:0] funct7,
                                     input logic [2:0] funct3);
    alu_op_t op;
    op = OP_ADD;
    if (opcode == OPCODE_BRANCH) begin
      op = OP_SUB;
    end else if (opcode == OPCODE_OP) begin
      case (funct7)
        FUNCT7_BASE: begin
          case (funct3)
            3'd0: op = OP_ADD;
            3'd1: op = OP_SLL;
            3'd2: op = OP_SLT;
            3'd3: op = OP_SLTU;
            3'd4: op = OP_XOR;
            3'd5: op = OP_SRL;
            3'd6: op = OP_OR;
            default: op = OP_AND;
          endcase
        end
        FUNCT7_ALT: begin
          if (funct3 == 3'd0) op = OP_SUB;
          else if (funct3 == 3'd5) op = OP_SRA;
        end
        FUNCT7_MULDIV: begin
          case (funct3)
            3'd0: op = OP_MUL;
            3'd1: op = OP_MULH;
            3'd2: op = OP_MULHSU;
            3'd3: op = OP_MULHU;
            3'd4: op = OP_DIV;
            3'd5: op = OP_DIVU;
            3'd6: op = OP_REM;
            default: op = OP_REMU;
          endcase
        end
        default: op = OP_ADD;
      endcase
    end
    return op;
  endfunction

  function automatic logic is_muldiv(input alu_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative magnitude multiplier / restoring divider, one bit per cycle, with sign fix-up.
module seq_muldiv_core
  import ula_pkg::*;
#(
  parameter int unsigned SIZE = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            abort_i,
  input  alu_op_t         op_i,
  input  logic [SIZE-1:0] a_i,
  input  logic [SIZE-1:0] b_i,
  output logic            last_o,
  output logic [SIZE-1:0] res_o
);

  localparam int unsigned CW = $clog2(SIZE) + 1;

  logic [2*SIZE-1:0] acc_q, acc_step, prod_fix;
  logic [SIZE-1:0]   opnd_q, mag_a, mag_b;
  logic [CW-1:0]     cnt_q;
  alu_op_t           op_q;
  logic              neg_q, sa, sb, neg, div_in, div_q;
  logic [SIZE:0]     mul_sum, rem_sh, diff;

  always_comb begin
    sa     = a_i[SIZE-1] && (op_i inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    sb     = b_i[SIZE-1] && (op_i inside {OP_MULH, OP_DIV, OP_REM});
    mag_a  = sa ? -a_i : a_i;
    mag_b  = sb ? -b_i : b_i;
    neg    = (op_i inside {OP_REM, OP_MULHSU}) ? sa : (sa ^ sb);
    div_in = op_i inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    div_q  = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  end

  // Multiply: shift-add into the upper half, multiplier shifts out of the bottom.
  // Divide: partial remainder in the upper half, quotient bits shift in at the bottom.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*SIZE-1:SIZE]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh  = acc_q[2*SIZE-1:SIZE-1];
    diff    = rem_sh - {1'b0, opnd_q};
    if (div_q) begin
      acc_step = diff[SIZE] ? {acc_q[2*SIZE-2:0], 1'b0}
                            : {diff[SIZE-1:0], acc_q[SIZE-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc_q[SIZE-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      op_q   <= OP_ADD;
      neg_q  <= 1'b0;
    end else if (abort_i) begin
      cnt_q <= '0;
    end else if (start_i) begin
      acc_q  <= {{SIZE{1'b0}}, (div_in ? mag_a : mag_b)};
      opnd_q <= div_in ? mag_b : mag_a;
      cnt_q  <= CW'(SIZE);
      op_q   <= op_i;
      neg_q  <= neg;
    end else if (cnt_q != '0) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign last_o   = (cnt_q == CW'(1));
  assign prod_fix = neg_q ? -acc_q : acc_q;

  always_comb begin
    case (op_q)
      OP_MUL:                       res_o = acc_q[SIZE-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_o = prod_fix[2*SIZE-1:SIZE];
      OP_DIV, OP_DIVU:              res_o = neg_q ? -acc_q[SIZE-1:0] : acc_q[SIZE-1:0];
      default:                      res_o = neg_q ? -acc_q[2*SIZE-1:SIZE] : acc_q[2*SIZE-1:SIZE];
    endcase
  end

endmodule

// File: rtl/ula_seq.sv
// Handshaked EX-stage ALU: single-cycle RV64I ops, iterative RV64M ops via seq_muldiv_core.
module ula_seq
  import ula_pkg::*;
#(
  parameter int unsigned SIZE = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] s1,
  input  logic [SIZE-1:0] s2,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [6:0]      opcode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] res,
  output logic            overflow,
  output logic            msb,
  output logic            zero,
  output logic            busy
);

  localparam int unsigned SHW = $clog2(SIZE);

  state_t          state_q;
  logic [SIZE-1:0] res_q, fast_res, y, md_res;
  logic [SIZE:0]   sum;
  logic [SHW-1:0]  shamt;
  logic            ovf_q, out_valid_q, fast_ovf, fast, sub, div_zero, div_ovf, md_last, md_start;
  alu_op_t         op;

  assign op       = decode(opcode, funct7, funct3);
  assign sub      = (op == OP_SUB);
  assign y        = s2 ^ {SIZE{sub}};
  assign sum      = {1'b0, s1} + {1'b0, y} + {{SIZE{1'b0}}, sub};
  assign shamt    = s2[SHW-1:0];
  assign div_zero = (s2 == '0);
  assign div_ovf  = (s1 == {1'b1, {(SIZE-1){1'b0}}}) && (s2 == '1);

  // Divide corner cases resolve here so they never enter the iterative core.
  always_comb begin
    fast_res = sum[SIZE-1:0];
    fast_ovf = 1'b0;
    fast     = 1'b1;
    case (op)
      OP_ADD, OP_SUB: fast_ovf = sum[SIZE];
      OP_SLL:  fast_res = s1 << shamt;
      OP_SLT:  fast_res = {{(SIZE-1){1'b0}}, $signed(s1) < $signed(s2)};
      OP_SLTU: fast_res = {{(SIZE-1){1'b0}}, s1 < s2};
      OP_XOR:  fast_res = s1 ^ s2;
      OP_SRL:  fast_res = s1 >> shamt;
      OP_SRA:  fast_res = $signed(s1) >>> shamt;
      OP_OR:   fast_res = s1 | s2;
      OP_AND:  fast_res = s1 & s2;
      OP_DIV: begin
        fast     = div_zero || div_ovf;
        fast_res = div_zero ? '1 : s1;
      end
      OP_DIVU: begin
        fast     = div_zero;
        fast_res = '1;
      end
      OP_REM: begin
        fast     = div_zero || div_ovf;
        fast_res = div_zero ? s1 : '0;
      end
      OP_REMU: begin
        fast     = div_zero;
        fast_res = s1;
      end
      default: fast = 1'b0;
    endcase
  end

  assign md_start = (state_q == ST_IDLE) && in_valid && !flush && !fast;

  seq_muldiv_core #(.SIZE(SIZE)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (md_start),
    .abort_i (flush),
    .op_i    (op),
    .a_i     (s1),
    .b_i     (s2),
    .last_o  (md_last),
    .res_o   (md_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            if (fast) begin
              res_q       <= fast_res;
              ovf_q       <= fast_ovf;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              state_q <= ST_CALC;
            end
          end
        end
        ST_CALC: if (md_last) state_q <= ST_FIX;
        ST_FIX: begin
          res_q       <= md_res;
          ovf_q       <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        default: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign res       = res_q;
  assign overflow  = ovf_q;
  assign out_valid = out_valid_q;
  assign msb       = res_q[SIZE-1];
  assign zero      = (res_q == '0);
  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/ula_seq.md
Name: ula_seq

Overview:
Parametrised, handshaked successor to the combinational ALU. It executes RV64I R-type integer ops in one cycle. It executes RV64M multiply/divide ops iteratively, one bit per cycle. It sits in the EX stage: it accepts an operand pair plus opcode/funct3/funct7 under a valid/ready handshake and returns a registered result with overflow/msb/zero flags under a second valid/ready handshake.

Parameters:
SIZE, 64, datapath width in bits (power of two, >= 8)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  synchronous abort; drops the in-flight op
in_valid  in  1  operands/op valid
in_ready  out  1  unit can accept (high only in IDLE)
s1  in  SIZE  operand 1
s2  in  SIZE  operand 2
funct7  in  7  instruction funct7
funct3  in  3  instruction funct3
opcode  in  7  instruction opcode
out_valid  out  1  result valid
out_ready  in  1  consumer takes result
res  out  SIZE  result
overflow  out  1  carry-out of add/sub; 0 for all other ops
msb  out  1  res[SIZE-1]
zero  out  1  res == 0
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; res=0, overflow=0, out_valid=0, busy=0, in_ready=1; msb=0, zero=1 (derived from res). Inputs are ignored while rst_n is low.
- Decode, opcode 0110011:
  - funct7 0000000, funct3 0..7: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - funct7 0100000: funct3 000 SUB, funct3 101 SRA.
  - funct7 0000001, funct3 0..7: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - Any other funct7/funct3 combination: ADD.
- Decode, other opcodes: 1100011 (branch) -> SUB; all other opcodes -> ADD (address generation).
- Shift amount is s2[log2(SIZE)-1:0]. SLT/SLTU return 0 or 1 in res.
- ADD/SUB use the shared adder with Y = s2 XOR {SIZE{sub}} and Cin = sub. overflow = Cout.
- FSM states IDLE, CALC, FIX, DONE.
  - IDLE: in_ready=1. On in_valid, simple ops (and the divide special cases below) compute combinationally and register into res; next state DONE. out_valid rises on the cycle after acceptance (latency 1).
  - IDLE, M op accepted: latch the operand magnitudes and sign flags, load step counter = SIZE, go to CALC.
  - CALC: one shift-add (MUL*) or restoring-subtract (DIV*/REM*) step per cycle. Counter decrements; at 0 go to FIX.
  - FIX: apply sign correction; select the low or high product half, or the quotient or remainder; register into res; go to DONE. M-op latency = SIZE+2 cycles from the acceptance edge to out_valid.
  - DONE: out_valid=1. res and flags hold stable while out_ready=0. On out_ready, go to IDLE with out_valid=0 on the next cycle. No new op is accepted in DONE.
- Divide special cases (resolved in IDLE with latency 1, no iteration):
  - Divisor 0: DIV/DIVU -> all ones; REM/REMU -> s1.
  - DIV with s1 = 1<<(SIZE-1) and s2 = -1: res = s1. The matching REM returns 0.
- Signed rules: quotient sign = sign(s1) XOR sign(s2); remainder takes the sign of s1. MULHSU treats s1 as signed and s2 as unsigned.
- flush: in any state, next state IDLE, out_valid=0, res unchanged. flush has priority over in_valid acceptance in the same cycle.
- rst_n asserted mid-CALC: immediate return to reset values; no partial result is ever presented.

Decomposition:
- Package ula_pkg holds:
  - OPCODE_OP / OPCODE_BRANCH constants
  - FUNCT7_BASE / FUNCT7_ALT / FUNCT7_MULDIV constants
  - the alu_op_t enum (all 18 ops)
  - the state_t enum
  - a decode function (opcode, funct7, funct3) -> alu_op_t
- One sub-module, seq_muldiv_core: iterative magnitude multiplier/divider holding the 2*SIZE accumulator, step counter and sign fix-up. ula_seq owns the decode, the simple-op datapath (reusing adder), the handshake FSM and the output registers.

Test Plan:
1. ADD, s1=5, s2=0xFFFF_FFFF_FFFF_FFFD, opcode 0110011, funct7 0, funct3 0 -> out_valid 1 cycle after accept, res=2, overflow=1, zero=0.
2. Branch opcode 1100011, s1=s2=7 -> res=0, zero=1, overflow=1, msb=0. SLT with s1=-1, s2=1 -> res=1.
3. DIV s1=-7, s2=2 -> res=0xFFFF_FFFF_FFFF_FFFD, out_valid exactly 66 cycles after accept. REM on the same operands -> res=0xFFFF_FFFF_FFFF_FFFF.
4. Divide special cases, each with latency 1:
   - DIVU s1=10, s2=0 -> res=all ones.
   - REMU s1=10, s2=0 -> res=10.
   - DIV s1=0x8000_0000_0000_0000, s2=-1 -> res=0x8000_0000_0000_0000.
5. MULHU s1=s2=all ones -> res=0xFFFF_FFFF_FFFF_FFFE. MUL with the same operands -> res=1. MULH s1=-2, s2=3 -> res=all ones.
6. Backpressure and abort:
   - Hold out_ready=0 for 5 cycles in DONE -> res stable, in_ready=0.
   - flush at CALC step 10 -> IDLE next cycle, out_valid never asserted.
   - rst_n low mid-CALC -> all outputs at reset values immediately.
